// File: rtl/gwin_pkg.sv
// gwin_pkg: shared defaults, counter-width helper and window-position type
// for green_window_3x3 and its line buffers.
package gwin_pkg;

    localparam int GWIN_DEF_WIDTH  = 640;
    localparam int GWIN_DEF_HEIGHT = 480;
    localparam int GWIN_DEF_DW     = 10;

    // Window-position type behind out_x / out_y.
    typedef int unsigned gwin_coord_t;

    // Width of a counter that indexes 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Centre index of the window registered when index idx is accepted.
    function automatic gwin_coord_t centre_coord(input gwin_coord_t idx);
        return idx - 1;
    endfunction

endpackage

// File: rtl/gwin_line_buffer.sv
// gwin_line_buffer: one video line of DW-bit samples, DEPTH entries.
// Ports: clk; we (write strobe); addr; wdata; rdata (entry at addr).
// Read-before-write: rdata always shows the contents before the write
// that lands on the next rising edge, so one address can be read and
// overwritten in the same cycle. Contents are never cleared.
module gwin_line_buffer
    import gwin_pkg::*;
#(
    parameter int DEPTH = GWIN_DEF_WIDTH,
    parameter int DW    = GWIN_DEF_DW,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/green_window_3x3.sv
// green_window_3x3: streaming 3x3 neighbourhood of interpolated green
// samples for the R/B-at-G interpolation stage.
// Ports: clk, rst_n (sync, active-low); in_valid/in_sof/in_g raster input;
// win_valid strobe with registered window G11..G33 (G1x newest row,
// Gx1 leftmost column, G22 centre). Optional macro GWIN_COORD_EN adds
// out_x/out_y, the centre coordinate of the current window.
module green_window_3x3
    import gwin_pkg::*;
#(
    parameter int IMG_WIDTH  = GWIN_DEF_WIDTH,
    parameter int IMG_HEIGHT = GWIN_DEF_HEIGHT,
    parameter int DW         = GWIN_DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_g,
    output logic          win_valid,
`ifdef GWIN_COORD_EN
    output logic [cnt_w(IMG_WIDTH)-1:0]  out_x,
    output logic [cnt_w(IMG_HEIGHT)-1:0] out_y,
`endif
    output logic [DW-1:0] G11,
    output logic [DW-1:0] G12,
    output logic [DW-1:0] G13,
    output logic [DW-1:0] G21,
    output logic [DW-1:0] G22,
    output logic [DW-1:0] G23,
    output logic [DW-1:0] G31,
    output logic [DW-1:0] G32,
    output logic [DW-1:0] G33
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_fire;
    logic          win_valid_q;

    logic [DW-1:0] lb0_rd, lb1_rd;

    // Row taps: 0 = current line, 1 = row-1 (LB0), 2 = row-2 (LB1).
    logic [DW-1:0] tap [3];
    // Per tap: [0] = column col-1, [1] = column col-2.
    logic [DW-1:0] sh_q [3][2];
    // Window registers in G11..G33 order.
    logic [DW-1:0] g_q [9];

    // Position of the pixel on the input this cycle; in_sof forces (0,0).
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // col >= 2 keeps all three columns on the current line, row >= 2
    // keeps stale line-buffer contents out of the window.
    assign win_fire = in_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

    gwin_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DW    (DW),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (in_g),
        .rdata (lb0_rd)
    );

    // LB1 takes the old LB0 entry, so it always lags LB0 by one line.
    gwin_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DW    (DW),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        tap[0] = in_g;
        tap[1] = lb0_rd;
        tap[2] = lb1_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int t = 0; t < 3; t++) begin
                sh_q[t][0] <= '0;
                sh_q[t][1] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                g_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_fire;
            if (in_valid) begin
                for (int t = 0; t < 3; t++) begin
                    sh_q[t][1] <= sh_q[t][0];
                    sh_q[t][0] <= tap[t];
                end
            end
            if (win_fire) begin
                for (int t = 0; t < 3; t++) begin
                    g_q[3*t]     <= sh_q[t][1];
                    g_q[3*t + 1] <= sh_q[t][0];
                    g_q[3*t + 2] <= tap[t];
                end
            end
        end
    end

`ifdef GWIN_COORD_EN
    logic [CW-1:0] x_q;
    logic [RW-1:0] y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (win_fire) begin
            x_q <= CW'(centre_coord(gwin_coord_t'(cur_col)));
            y_q <= RW'(centre_coord(gwin_coord_t'(cur_row)));
        end
    end

    assign out_x = x_q;
    assign out_y = y_q;
`endif

    assign win_valid = win_valid_q;
    assign G11 = g_q[0];
    assign G12 = g_q[1];
    assign G13 = g_q[2];
    assign G21 = g_q[3];
    assign G22 = g_q[4];
    assign G23 = g_q[5];
    assign G31 = g_q[6];
    assign G32 = g_q[7];
    assign G33 = g_q[8];

endmodule

// File: tb/tb_green_window_3x3.sv
// tb_green_window_3x3: directed bench for green_window_3x3 at 8x6,
// pixel value row*16+col; define GWIN_COORD_EN to also cover out_x/out_y.
module tb_green_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 10;
    localparam int WIN_PER_FRAME = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_g = '0;
    logic          win_valid;
    logic [DW-1:0] G11, G12, G13, G21, G22, G23, G31, G32, G33;
`ifdef GWIN_COORD_EN
    logic [2:0]    out_x;
    logic [2:0]    out_y;
`endif

    green_window_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DW         (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_g      (in_g),
        .win_valid (win_valid),
`ifdef GWIN_COORD_EN
        .out_x     (out_x),
        .out_y     (out_y),
`endif
        .G11 (G11), .G12 (G12), .G13 (G13),
        .G21 (G21), .G22 (G22), .G23 (G23),
        .G31 (G31), .G32 (G32), .G33 (G33)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int wv;
        int g11;
        int g13;
        int g22;
        int g31;
        int g33;
        int x;
        int y;
    } spot_t;

    spot_t spots [7];

    int n_chk = 0;
    int n_fail = 0;
    int dut_win = 0;
    int exp_g [9];
    int exp_x = 0;
    int exp_y = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gact(input int k);
        int v;
        v = 0;
        case (k)
            0: v = int'(G11);
            1: v = int'(G12);
            2: v = int'(G13);
            3: v = int'(G21);
            4: v = int'(G22);
            5: v = int'(G23);
            6: v = int'(G31);
            7: v = int'(G32);
            default: v = int'(G33);
        endcase
        return v;
    endfunction

    // One clock: drive at negedge, sample 1 ns after the rising edge and
    // compare against the window model for pixel (r,c).
    task automatic step(input bit v, input bit s, input int r, input int c);
        bit fire;
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_g     = v ? DW'(r * 16 + c) : DW'($urandom);
        @(posedge clk);
        #1;
        fire = v && (r >= 2) && (c >= 2);
        if (fire) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    exp_g[i*3 + j] = (r - i) * 16 + (c - 2 + j);
                end
            end
            exp_x = c - 1;
            exp_y = r - 1;
        end
        if (win_valid) dut_win++;
        check(v ? "win_valid" : "win_valid_gap", int'(win_valid), int'(fire));
        if (fire) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("G%0d%0d@(%0d,%0d)", k/3 + 1, k%3 + 1, r, c),
                      gact(k), exp_g[k]);
            end
        end else begin
            check("G22_hold", gact(4), exp_g[4]);
        end
`ifdef GWIN_COORD_EN
        check("out_x", int'(out_x), exp_x);
        check("out_y", int'(out_y), exp_y);
`endif
    endtask

    task automatic spot_check(input int r, input int c);
        foreach (spots[k]) begin
            if (spots[k].r == r && spots[k].c == c) begin
                check($sformatf("spot(%0d,%0d) wv", r, c), int'(win_valid), spots[k].wv);
                check($sformatf("spot(%0d,%0d) G11", r, c), int'(G11), spots[k].g11);
                check($sformatf("spot(%0d,%0d) G13", r, c), int'(G13), spots[k].g13);
                check($sformatf("spot(%0d,%0d) G22", r, c), int'(G22), spots[k].g22);
                check($sformatf("spot(%0d,%0d) G31", r, c), int'(G31), spots[k].g31);
                check($sformatf("spot(%0d,%0d) G33", r, c), int'(G33), spots[k].g33);
`ifdef GWIN_COORD_EN
                check($sformatf("spot(%0d,%0d) x", r, c), int'(out_x), spots[k].x);
                check($sformatf("spot(%0d,%0d) y", r, c), int'(out_y), spots[k].y);
`endif
            end
        end
    endtask

    // Stream a frame in raster order, stopping before (stop_r,stop_c).
    task automatic stream(input bit sof0, input int gap_pct,
                          input int stop_r, input int stop_c, input bit use_tbl);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (gap_pct > 0) begin
                    for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
                        step(1'b0, 1'($urandom_range(0, 1)), 0, 0);
                    end
                end
                step(1'b1, sof0 && r == 0 && c == 0, r, c);
                if (use_tbl) spot_check(r, c);
            end
        end
    endtask

    initial begin
        //          r  c  wv g11 g13 g22 g31 g33 x  y
        spots[0] = '{1, 7, 0,  0,  0,  0,  0,  0, 0, 0};
        spots[1] = '{2, 1, 0,  0,  0,  0,  0,  0, 0, 0};
        spots[2] = '{2, 2, 1, 32, 34, 17,  0,  2, 1, 1};
        spots[3] = '{3, 0, 0, 37, 39, 22,  5,  7, 6, 1};
        spots[4] = '{3, 2, 1, 48, 50, 33, 16, 18, 1, 2};
        spots[5] = '{4, 4, 1, 66, 68, 51, 34, 36, 3, 3};
        spots[6] = '{5, 7, 1, 85, 87, 70, 53, 55, 6, 4};
        foreach (exp_g[k]) exp_g[k] = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset win_valid", int'(win_valid), 0);
        check("reset G11", int'(G11), 0);
        check("reset G22", int'(G22), 0);
        check("reset G33", int'(G33), 0);
`ifdef GWIN_COORD_EN
        check("reset out_x", int'(out_x), 0);
        check("reset out_y", int'(out_y), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame with hand-computed spot checks
        dut_win = 0;
        stream(1'b1, 0, -1, -1, 1'b1);
        check("frame_A windows", dut_win, WIN_PER_FRAME);

        // Random idle gaps, stray in_sof while idle
        dut_win = 0;
        stream(1'b1, 30, -1, -1, 1'b0);
        check("frame_gaps windows", dut_win, WIN_PER_FRAME);

        // in_sof arrives at (4,5): restart with a full frame
        stream(1'b1, 0, 4, 5, 1'b0);
        dut_win = 0;
        stream(1'b1, 0, -1, -1, 1'b0);
        check("sof_restart windows", dut_win, WIN_PER_FRAME);

        // One-cycle reset mid-frame right after a window
        stream(1'b1, 0, 3, 3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("midreset win_valid", int'(win_valid), 0);
        check("midreset G11", int'(G11), 0);
        check("midreset G22", int'(G22), 0);
        check("midreset G33", int'(G33), 0);
`ifdef GWIN_COORD_EN
        check("midreset out_x", int'(out_x), 0);
        check("midreset out_y", int'(out_y), 0);
`endif
        foreach (exp_g[k]) exp_g[k] = 0;
        exp_x = 0;
        exp_y = 0;
        @(negedge clk);
        rst_n = 1'b1;
        dut_win = 0;
        stream(1'b0, 0, -1, -1, 1'b1);
        check("reset_restart windows", dut_win, WIN_PER_FRAME);

        @(negedge clk);
        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
